// File: rtl/seq_det_moore_param.sv
// seq_det_moore_param: parametrised Moore serial pattern detector with KMP transitions and saturating match counter (counter enabled by SEQ_DET_COUNT_EN)
module seq_det_moore_param #(
    parameter int                 SEQ_LEN = 4,
    parameter logic [SEQ_LEN-1:0] SEQ     = 4'b1011,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         clr,
    input  logic                         x,
    output logic                         y,
    output logic [$clog2(SEQ_LEN+1)-1:0] state,
    output logic [CNT_W-1:0]             match_cnt
);

    localparam int          SW = $clog2(SEQ_LEN + 1);
    localparam int unsigned PV = 32'(SEQ);

    if (SEQ_LEN < 2 || SEQ_LEN > 16) begin : g_bad_len
        $error("seq_det_moore_param: SEQ_LEN must be in 2..16");
    end

    // Pattern bit i, where bit SEQ_LEN-1 is received first.
    function automatic int bit_at(input int i);
        return int'((PV >> i) & 32'd1);
    endfunction

    // First k received bits of the pattern, as a k-bit value.
    function automatic int pre(input int k);
        return int'(PV >> (SEQ_LEN - k));
    endfunction

    // Longest proper border of the length-s pattern prefix.
    function automatic int fail_of(input int s);
        int r;
        r = 0;
        for (int k = 1; k < s; k++)
            if ((pre(s) & ((1 << k) - 1)) == pre(k)) r = k;
        return r;
    endfunction

    // Full KMP automaton transition from prefix length s on input bit b.
    function automatic int delta(input int s, input int b);
        int k;
        if (s < SEQ_LEN && b == bit_at(SEQ_LEN - 1 - s)) return s + 1;
        if (s == 0) return 0;
        k = fail_of(s);
        for (int i = 0; i < SEQ_LEN; i++)
            if (k > 0 && b != bit_at(SEQ_LEN - 1 - k)) k = fail_of(k);
        return (b == bit_at(SEQ_LEN - 1 - k)) ? k + 1 : 0;
    endfunction

    logic [SW-1:0] tab0 [SEQ_LEN+1];
    logic [SW-1:0] tab1 [SEQ_LEN+1];

    for (genvar s = 0; s <= SEQ_LEN; s++) begin : g_tab
        localparam logic [SW-1:0] T0 = SW'(delta(s, 0));
        localparam logic [SW-1:0] T1 = SW'(delta(s, 1));
        assign tab0[s] = T0;
        assign tab1[s] = T1;
    end

    logic [SW-1:0] nxt;
    logic          hit;

    // Next prefix length: table lookup, except a non-overlapping search restarts after a match.
    always_comb begin
        nxt = x ? tab1[state] : tab0[state];
        if (!OVERLAP && state == SW'(SEQ_LEN))
            nxt = (x == SEQ[SEQ_LEN-1]) ? SW'(1) : SW'(0);
        hit = (nxt == SW'(SEQ_LEN));
    end

    // State and registered Moore flag; clear wins over any match on the same enabled edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= '0;
            y     <= 1'b0;
        end else if (enable) begin
            state <= clr ? '0 : nxt;
            y     <= clr ? 1'b0 : hit;
        end
    end

`ifdef SEQ_DET_COUNT_EN
    // Saturating count of completed matches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            match_cnt <= '0;
        else if (enable) begin
            if (clr)
                match_cnt <= '0;
            else if (hit && match_cnt != {CNT_W{1'b1}})
                match_cnt <= match_cnt + 1'b1;
        end
    end
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_det_moore_param.sv
// tb_seq_det_moore_param: scoreboard bench for three detector configurations driven by one shared stream
module tb_seq_det_moore_param;

    typedef struct packed {
        logic [2:0] st;
        logic       y;
        logic [7:0] c;
    } ent_t;

    logic       clk, rst_n, enable, clr, x;
    logic       y0, y1, y2;
    logic [2:0] s0, s1, s2;
    logic [7:0] c0, c1;
    logic [1:0] c2;

    int ncmp = 0;
    int nerr = 0;
    ent_t q[$];

    logic [3:0]  sq   [3] = '{4'b1011, 4'b1011, 4'b1111};
    bit          ov   [3] = '{1'b1, 1'b0, 1'b1};
    int          cmax [3] = '{255, 255, 3};
    logic [31:0] m_h  [3];
    int          m_n  [3];
    int          m_st [3];
    int          m_c  [3];

    seq_det_moore_param #(.SEQ_LEN(4), .SEQ(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) d0 (
        .clk(clk), .reset(rst_n), .enable(enable), .clr(clr), .x(x),
        .y(y0), .state(s0), .match_cnt(c0));
    seq_det_moore_param #(.SEQ_LEN(4), .SEQ(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) d1 (
        .clk(clk), .reset(rst_n), .enable(enable), .clr(clr), .x(x),
        .y(y1), .state(s1), .match_cnt(c1));
    seq_det_moore_param #(.SEQ_LEN(4), .SEQ(4'b1111), .OVERLAP(1'b1), .CNT_W(2)) d2 (
        .clk(clk), .reset(rst_n), .enable(enable), .clr(clr), .x(x),
        .y(y2), .state(s2), .match_cnt(c2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Longest k <= n such that the last k bits equal the first k pattern bits.
    function automatic int exp_st(input logic [31:0] h, input int n, input logic [3:0] p);
        int r;
        r = 0;
        for (int k = 1; k <= 4 && k <= n; k++)
            if ((h & ((32'd1 << k) - 32'd1)) == (32'(p) >> (4 - k))) r = k;
        return r;
    endfunction

    function automatic logic [31:0] got_of(input int i, input int f);
        case (f)
            0: return (i == 0) ? 32'(s0) : (i == 1) ? 32'(s1) : 32'(s2);
            1: return (i == 0) ? 32'(y0) : (i == 1) ? 32'(y1) : 32'(y2);
            default: return (i == 0) ? 32'(c0) : (i == 1) ? 32'(c1) : 32'(c2);
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_h[i] = '0; m_n[i] = 0; m_st[i] = 0; m_c[i] = 0;
        end
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s d%0d.state", tag, i), got_of(i, 0), 0);
            chk($sformatf("%s d%0d.y", tag, i), got_of(i, 1), 0);
            chk($sformatf("%s d%0d.cnt", tag, i), got_of(i, 2), 0);
        end
    endtask

    task automatic step(input logic e, input logic c, input logic xv);
        ent_t r;
        enable = e; clr = c; x = xv;
        for (int i = 0; i < 3; i++) begin
            if (e) begin
                if (c) begin
                    m_n[i] = 0; m_st[i] = 0; m_c[i] = 0;
                end else begin
                    m_h[i] = {m_h[i][30:0], xv};
                    m_n[i] = (m_n[i] < 16) ? m_n[i] + 1 : 16;
                    m_st[i] = exp_st(m_h[i], m_n[i], sq[i]);
                    if (m_st[i] == 4) begin
`ifdef SEQ_DET_COUNT_EN
                        if (m_c[i] < cmax[i]) m_c[i]++;
`endif
                        if (!ov[i]) m_n[i] = 0;
                    end
                end
            end
            r.st = 3'(m_st[i]);
            r.y  = (m_st[i] == 4);
            r.c  = 8'(m_c[i]);
            q.push_back(r);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            r = q.pop_front();
            chk($sformatf("d%0d.state", i), got_of(i, 0), 32'(r.st));
            chk($sformatf("d%0d.y", i), got_of(i, 1), 32'(r.y));
            chk($sformatf("d%0d.cnt", i), got_of(i, 2), 32'(r.c));
        end
    endtask

    task automatic stream(input logic [31:0] bits, input int n);
        for (int k = n - 1; k >= 0; k--) step(1'b1, 1'b0, bits[k]);
    endtask

    initial begin
        logic [31:0] pat;
        rst_n = 1'b0; enable = 1'b0; clr = 1'b0; x = 1'b0;
        model_reset();
        #2;
        check_zero("reset");
        #5;
        rst_n = 1'b1;
        pat = 32'b1011;
        stream(pat, 4);
        step(1'b1, 1'b1, 1'b0);
        pat = 32'b1011011;
        stream(pat, 7);
        step(1'b1, 1'b1, 1'b0);
        pat = 32'b101;
        stream(pat, 3);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        stream(pat, 3);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        #1;
        rst_n = 1'b1;
        stream(pat, 3);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        pat = 32'hFF;
        stream(pat, 8);
        for (int k = 0; k < 80; k++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 1'($urandom));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
